// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit and its queue.
package fetch_pkg;

    localparam int INSTR_W = 32;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FAULT = 2'd2
    } fetch_state_t;

    // Queue entry layout: {pc, instr}.
    typedef struct packed {
        logic [31:0]        pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Small circular FIFO between fetch and decode; flush empties it in one cycle.
module fetch_queue #(
    parameter int QDEPTH = 2,
    parameter int W      = 64,
    localparam int PW    = (QDEPTH > 1) ? $clog2(QDEPTH) : 1,
    localparam int CW    = $clog2(QDEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  logic [W-1:0]  push_data,
    output logic [CW-1:0] count,
    output logic [W-1:0]  head_data
);

    logic [W-1:0]  mem [QDEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic          do_pop;
    logic          do_push;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        if (p == PW'(QDEPTH - 1)) return '0;
        return p + PW'(1);
    endfunction

    assign do_pop    = pop && (count != '0);
    // A push into a full queue is only legal when the head leaves this cycle.
    assign do_push   = push && ((count != CW'(QDEPTH)) || do_pop);
    assign head_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= next_ptr(wr_ptr);
            if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && !flush && do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: sequential PC, redirect handling and a short queue to decode.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_BOOT  | one idle cycle after reset, imem_addr held at RESET_PC
//   ST_RUN   | fetching; pushes into the queue whenever a slot is free
//   ST_FAULT | misaligned redirect seen; fetch frozen until reset
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int          DEPTH    = 256,
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          QDEPTH   = 2,
    localparam int         AW       = $clog2(DEPTH),
    localparam int         CW       = $clog2(QDEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic [AW-1:0]      imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               redirect_valid,
    input  logic [31:0]        redirect_pc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [31:0]        out_pc,
    output logic [31:0]        out_pc_plus4,
    output logic               misalign_err
);

    fetch_state_t state;
    fetch_state_t next_state;
    logic [31:0]  pc;
    logic [31:0]  pc_next;
    logic         err_next;
    logic         push;
    logic         pop;
    logic         flush;
    logic [CW-1:0] count;
    fetch_entry_t push_entry;
    fetch_entry_t head_entry;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= ST_BOOT;
            pc           <= RESET_PC;
            misalign_err <= 1'b0;
        end else begin
            state        <= next_state;
            pc           <= pc_next;
            misalign_err <= err_next;
        end
    end

    always_comb begin
        next_state = state;
        pc_next    = pc;
        err_next   = misalign_err;
        push       = 1'b0;
        flush      = 1'b0;
        case (state)
            ST_BOOT: next_state = ST_RUN;
            ST_RUN: begin
                if (redirect_valid) begin
                    flush = 1'b1;
                    if (redirect_pc[1:0] != 2'b00) begin
                        err_next   = 1'b1;
                        next_state = ST_FAULT;
                    end else begin
                        pc_next = redirect_pc;
                    end
                end else if ((count < CW'(QDEPTH)) || ((count == CW'(QDEPTH)) && pop)) begin
                    push    = 1'b1;
                    pc_next = pc + 32'd4;
                end
            end
            ST_FAULT: next_state = ST_FAULT;
            default:  next_state = ST_BOOT;
        endcase
    end

    // Reset is folded in so decode sees no stale head while rst_n is low.
    assign out_valid = rst_n && (state == ST_RUN) && (count != '0);
    assign pop       = out_valid && out_ready;
    assign imem_addr = (!rst_n || state == ST_BOOT) ? RESET_PC[AW+1:2] : pc[AW+1:2];

    assign push_entry.pc    = pc;
    assign push_entry.instr = imem_rdata;

    fetch_queue #(
        .QDEPTH (QDEPTH),
        .W      ($bits(fetch_entry_t))
    ) u_queue (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .pop       (pop),
        .flush     (flush),
        .push_data (push_entry),
        .count     (count),
        .head_data (head_entry)
    );

    assign out_instr    = head_entry.instr;
    assign out_pc       = head_entry.pc;
    assign out_pc_plus4 = head_entry.pc + 32'd4;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed and random checks of fetch_unit against a queue-based reference model.
module tb_fetch_unit;

    localparam int          DEPTH    = 256;
    localparam int          QDEPTH   = 2;
    localparam int          AW       = $clog2(DEPTH);
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_rdata;
    logic          redirect_valid;
    logic [31:0]   redirect_pc;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   out_instr;
    logic [31:0]   out_pc;
    logic [31:0]   out_pc_plus4;
    logic          misalign_err;

    logic [31:0] mem [DEPTH];
    assign imem_rdata = mem[imem_addr];

    always #5 clk = ~clk;

    fetch_unit #(
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC),
        .QDEPTH   (QDEPTH)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .out_pc_plus4   (out_pc_plus4),
        .misalign_err   (misalign_err)
    );

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] m_pc;
    bit          m_boot;
    bit          m_fault;

    function automatic int widx(input logic [31:0] byte_addr);
        return int'((byte_addr >> 2) % 32'(DEPTH));
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: apply inputs, compare outputs with the model, advance the model.
    task automatic step(input bit rst, input bit rv, input logic [31:0] rpc, input bit rdy);
        bit          exp_valid;
        bit          popped;
        bit          can_push;
        logic [31:0] exp_addr;
        ent_t        e;
        rst_n          = rst;
        redirect_valid = rv;
        redirect_pc    = rpc;
        out_ready      = rdy;
        #1;
        exp_valid = rst && !m_boot && !m_fault && (mq.size() != 0);
        exp_addr  = (!rst || m_boot) ? 32'(widx(RESET_PC)) : 32'(widx(m_pc));
        chk("out_valid", 32'(out_valid), 32'(exp_valid));
        chk("imem_addr", 32'(imem_addr), exp_addr);
        chk("misalign_err", 32'(misalign_err), 32'(m_fault));
        if (exp_valid) begin
            chk("out_pc", out_pc, mq[0].pc);
            chk("out_instr", out_instr, mq[0].instr);
            chk("out_pc_plus4", out_pc_plus4, mq[0].pc + 32'd4);
        end
        if (!rst) begin
            mq.delete();
            m_pc    = RESET_PC;
            m_boot  = 1'b1;
            m_fault = 1'b0;
        end else if (m_boot) begin
            m_boot = 1'b0;
        end else if (!m_fault) begin
            if (rv) begin
                mq.delete();
                if (rpc[1:0] != 2'b00) m_fault = 1'b1;
                else                   m_pc    = rpc;
            end else begin
                popped   = exp_valid && rdy;
                can_push = (mq.size() < QDEPTH) || popped;
                if (popped) void'(mq.pop_front());
                if (can_push) begin
                    e.pc    = m_pc;
                    e.instr = mem[widx(m_pc)];
                    mq.push_back(e);
                    m_pc = m_pc + 32'd4;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit          rv;
        bit          rdy;
        bit          rst;
        logic [31:0] rpc;

        for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
        mem[0]  = 32'h00500113;
        mem[1]  = 32'h00c00193;
        mem[2]  = 32'hff718393;
        mem[16] = 32'h00910133;

        rst_n = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        mq.delete(); m_pc = RESET_PC; m_boot = 1'b1; m_fault = 1'b0;

        // Reset release, streaming with out_ready high.
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        step(1, 0, 0, 1);
        step(1, 0, 0, 1);
        chk("first_pc", out_pc, 32'h0);
        chk("first_instr", out_instr, 32'h00500113);
        step(1, 0, 0, 0);
        repeat (4) step(1, 0, 0, 0);
        chk("stall_pc", out_pc, 32'h0);
        chk("stall_addr", 32'(imem_addr), 32'd2);
        repeat (4) step(1, 0, 0, 1);

        // Reset in the middle of a stall.
        repeat (3) step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        step(1, 0, 0, 1);
        step(1, 0, 0, 1);
        chk("restart_pc", out_pc, 32'h0);
        chk("restart_instr", out_instr, 32'h00500113);
        repeat (3) step(1, 0, 0, 1);

        // Redirect with a full queue.
        repeat (3) step(1, 0, 0, 0);
        step(1, 1, 32'h40, 0);
        chk("redir_gap", 32'(out_valid), 32'd0);
        step(1, 0, 0, 1);
        chk("redir_pc", out_pc, 32'h40);
        chk("redir_instr", out_instr, 32'h00910133);
        chk("redir_plus4", out_pc_plus4, 32'h44);
        repeat (3) step(1, 0, 0, 1);

        // Address aliasing past the end of memory.
        step(1, 1, 32'h3FC, 1);
        step(1, 0, 0, 1);
        chk("alias_addr", 32'(imem_addr), 32'd0);
        step(1, 0, 0, 1);
        chk("alias_pc", out_pc, 32'h400);
        chk("alias_instr", out_instr, 32'h00500113);
        repeat (2) step(1, 0, 0, 1);

        // PC wrap at the top of the 32-bit space.
        step(1, 1, 32'hFFFF_FFF8, 1);
        repeat (5) step(1, 0, 0, $urandom_range(0, 1) == 1);

        // Random traffic with aligned redirects and occasional resets.
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 63) != 0);
            rdy = ($urandom_range(0, 3) != 0);
            rv  = ($urandom_range(0, 11) == 0);
            rpc = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, DEPTH * 4 + 63)) : $urandom;
            rpc[1:0] = 2'b00;
            step(rst, rv, rpc, rdy);
        end
        repeat (3) step(1, 0, 0, 1);

        // Misaligned redirect: sticky fault that ignores later redirects.
        step(1, 1, 32'h42, 1);
        chk("fault_err", 32'(misalign_err), 32'd1);
        chk("fault_valid", 32'(out_valid), 32'd0);
        for (int i = 0; i < 10; i++) step(1, i == 3, 32'h0, 1);
        chk("fault_sticky", 32'(misalign_err), 32'd1);

        // Reset clears the fault and fetch restarts.
        step(0, 0, 0, 1);
        repeat (5) step(1, 0, 0, 1);
        chk("post_fault_err", 32'(misalign_err), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter DEPTH, default 256: instruction memory words; address width AW = $clog2(DEPTH).
REQ-002 SHALL have parameter RESET_PC, default 32'h0000_0000: first fetch address.
REQ-003 SHALL have parameter QDEPTH, default 2: fetch queue entries.
REQ-004 SHALL have port clk, input, 1: sole clock; all state updates on rising edge.
REQ-005 SHALL have port rst_n, input, 1: reset, synchronous and active-low.
REQ-006 SHALL have port imem_addr, output, AW: word index to instruction memory, equal to pc[AW+1:2].
REQ-007 SHALL have port imem_rdata, input, 32: combinational read data for imem_addr, valid in the same cycle.
REQ-008 SHALL have port redirect_valid, input, 1: branch or jump taken this cycle.
REQ-009 SHALL have port redirect_pc, input, 32: target byte address.
REQ-010 SHALL have port out_valid, output, 1: queue head valid to decode.
REQ-011 SHALL have port out_ready, input, 1: decode accepts the head.
REQ-012 SHALL have ports out_instr (32), out_pc (32) and out_pc_plus4 (32), all outputs: head instruction, its address, and that address + 4.
REQ-013 SHALL have port misalign_err, output, 1: sticky misaligned-redirect fault.

Function
REQ-014 SHALL implement FSM states BOOT, RUN and FAULT: BOOT->RUN unconditionally after one cycle; RUN->FAULT on a misaligned redirect; FAULT exits only by reset.
REQ-015 SHALL, in RUN with no redirect, push {pc, imem_rdata} and advance pc by 4 when count < QDEPTH, or when count == QDEPTH and a pop occurs in the same cycle.
REQ-016 SHALL hold pc and perform no push when the push condition is false.
REQ-017 SHALL pop on out_valid && out_ready; out_valid = (count != 0).
REQ-018 SHALL give push-to-out_valid latency of one cycle: an entry pushed in cycle N is visible in cycle N+1.
REQ-019 SHALL give redirect_valid priority over push and pop: flush the queue (count=0), load pc=redirect_pc, no push that cycle; out_valid=0 the next cycle; target visible two cycles after redirect.
REQ-020 SHALL treat a redirect with redirect_pc[1:0] != 0 as misaligned: flush, leave pc unchanged, set misalign_err=1, go to FAULT.
REQ-021 SHALL, in FAULT, perform no pushes, keep out_valid=0 and ignore redirect_valid.
REQ-022 SHALL compute pc + 4 modulo 2^32; imem_addr aliases modulo DEPTH (pc 0x400 -> imem_addr 0 at DEPTH=256) without raising an error.
REQ-023 SHALL compute out_pc_plus4 = out_pc + 4 modulo 2^32, combinationally from the head entry.
REQ-024 SHALL keep queue order FIFO; simultaneous push and pop at count==QDEPTH leaves count unchanged.

Reset
REQ-025 SHALL, when rst_n==0 at a clock edge, set state=BOOT, pc=RESET_PC, count=0, queue pointers=0, misalign_err=0, and ignore all inputs.
REQ-026 SHALL hold out_valid=0 and imem_addr=RESET_PC[AW+1:2] during reset and BOOT; queue data need not be cleared.
REQ-027 SHALL discard in-flight entries and any stall when reset is asserted mid-operation.

Structure
REQ-028 SHALL place the FSM state enum, INSTR_W=32 and the default RESET_PC in shared package fetch_pkg.
REQ-029 SHALL implement the queue as sub-module fetch_queue (parameters QDEPTH, width 64; ports push, pop, flush, count, head data) with the same clk and rst_n.

Verification (memory preloaded: [0]=00500113, [1]=00c00193, [2]=ff718393, [16]=00910133)
REQ-030 SHALL cover reset release with out_ready=1: cycle 1 BOOT, out_valid=0; cycle 3 gives out_pc=0x0, out_instr=00500113; cycle 4 gives 0x4 with 00c00193; one instruction per cycle thereafter.
REQ-031 SHALL cover out_ready=0 for 5 cycles after first valid: count saturates at 2, pc holds 0x8, out_pc stays 0x0; on out_ready=1, out_pc sequence is 0x0, 0x4, 0x8 with no gap.
REQ-032 SHALL cover redirect_pc=0x40 with a full queue: next cycle out_valid=0; the cycle after, out_pc=0x40, out_instr=00910133, out_pc_plus4=0x44.
REQ-033 SHALL cover redirect_pc=0x42: next cycle misalign_err=1 and out_valid=0, then stays so for 10 cycles despite a further redirect to 0x0.
REQ-034 SHALL cover redirect_pc=0x3FC with out_ready=1: the following fetch drives imem_addr=0, out_pc=0x400, out_instr=00500113.
REQ-035 SHALL cover rst_n low for one cycle during the stall of REQ-031: count=0, out_valid=0, and restart at out_pc=0x0 per REQ-030 timing.
